// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder built around one half-adder-pair full-adder cell

// Single-bit half adder: the building block of the serial full-adder cell.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// Adds two WIDTH-bit operands one bit per clock, LSB first.
// A result is committed to sum/cout with a one-cycle done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Partial sum collected so far. Only WIDTH-1 bits are ever needed: the
    // final bit arrives on the commit edge and goes straight into sum, and
    // the bit that would sit at position 0 is always the cleared start value.
    logic [WIDTH-2:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    count;

    logic             accept;
    logic             last_bit;
    logic             p_bit;
    logic             g_ab;
    logic             g_pc;
    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] shift_word;

    // Full-adder cell: two half adders plus an OR for the carry.
    half_adder u_ha_ab (
        .x (a_sr[0]),
        .y (b_sr[0]),
        .s (p_bit),
        .c (g_ab)
    );

    half_adder u_ha_pc (
        .x (p_bit),
        .y (carry),
        .s (s_bit),
        .c (g_pc)
    );

    assign c_next     = g_ab | g_pc;
    assign accept     = (state == IDLE) && start;
    assign last_bit   = (count == CW'(WIDTH - 1));
    // New sum bit enters at the MSB; the whole word is the committed result
    // on the last bit and its upper WIDTH-1 bits are the next partial sum.
    assign shift_word = {s_bit, sum_sr};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept start only when idle, return after the last bit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: busy depends only on the registered state.
    always_comb begin
        busy = 1'b0;
        if (state == SHIFT) begin
            busy = 1'b1;
        end
    end

    // Datapath: load operands on accept, shift one bit per cycle, commit on the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sr   <= a;
                b_sr   <= b;
                carry  <= cin;
                sum_sr <= '0;
                count  <= '0;
            end else if (state == SHIFT) begin
                a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                sum_sr <= shift_word[WIDTH-1:1];
                carry  <= c_next;
                count  <= count + CW'(1);
                if (last_bit) begin
                    sum  <= shift_word;
                    cout <= c_next;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH=8 and WIDTH=4

module tb_serial_adder;

    logic       clk;
    logic       rst;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       cin4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int checks;
    int errors;

    logic [8:0] q8[$];
    logic [4:0] q4[$];

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor for the WIDTH=8 instance: every done must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && done8 === 1'b1) begin
            if (q8.size() == 0) begin
                check(1'b0, "done8_unexpected", {23'd0, sum8, cout8}, 32'd0);
            end else begin
                logic [8:0] e;
                e = q8.pop_front();
                check({sum8, cout8} === e, "result8", {23'd0, sum8, cout8}, {23'd0, e});
            end
        end
    end

    // Monitor for the WIDTH=4 instance.
    always @(negedge clk) begin
        if (!rst && done4 === 1'b1) begin
            if (q4.size() == 0) begin
                check(1'b0, "done4_unexpected", {27'd0, sum4, cout4}, 32'd0);
            end else begin
                logic [4:0] e;
                e = q4.pop_front();
                check({sum4, cout4} === e, "result4", {27'd0, sum4, cout4}, {27'd0, e});
            end
        end
    end

    task automatic start8_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                             input bit push, input logic [8:0] exp);
        @(negedge clk);
        a8 = a;
        b8 = b;
        cin8 = c;
        start8 = 1'b1;
        if (push) q8.push_back(exp);
        @(posedge clk);
        #1 start8 = 1'b0;
    endtask

    // Waits from mid-cycle until the done negedge of the WIDTH=8 instance.
    task automatic wait_done8(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (done8 !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check(1'b0, name, 32'(n), 32'd60);
    endtask

    // Counts busy cycles after an accept and checks done follows immediately.
    task automatic measure8(input string name, input int exp_cycles);
        int n;
        n = 0;
        @(negedge clk);
        while (busy8 === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        check(n == exp_cycles, {name, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
        check(done8 === 1'b1, {name, "_done_after_busy"}, {31'd0, done8}, 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

        // Async reset takes effect before any clock edge.
        #1;
        check({busy8, done8, sum8, cout8} === 11'd0, "reset8_outputs", {21'd0, busy8, done8, sum8, cout8}, 32'd0);
        check({busy4, done4, sum4, cout4} === 7'd0, "reset4_outputs", {25'd0, busy4, done4, sum4, cout4}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle with start low for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check({busy8, done8, sum8, cout8} === 11'd0, "idle8", {21'd0, busy8, done8, sum8, cout8}, 32'd0);
        end

        // Basic add: 0x5A + 0x3C = 0x96, busy exactly 8 cycles.
        start8_op(8'h5A, 8'h3C, 1'b0, 1'b1, {8'h96, 1'b0});
        measure8("basic", 8);

        // Carry chain.
        start8_op(8'hFF, 8'h01, 1'b0, 1'b1, {8'h00, 1'b1});
        wait_done8("timeout_ff_01");
        start8_op(8'hFF, 8'hFF, 1'b1, 1'b1, {8'hFF, 1'b1});
        wait_done8("timeout_ff_ff");

        // Busy protection: second start during the add is ignored.
        start8_op(8'h10, 8'h20, 1'b0, 1'b1, {8'h30, 1'b0});
        repeat (3) @(negedge clk);
        a8 = 8'hAA;
        b8 = 8'h55;
        start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        wait_done8("timeout_busy_prot");
        repeat (15) @(negedge clk);
        check(sum8 === 8'h30, "busy_prot_sum_hold", {24'd0, sum8}, 32'h30);
        check(busy8 === 1'b0, "busy_prot_idle", {31'd0, busy8}, 32'd0);

        // Back-to-back: new start in the done cycle.
        start8_op(8'h01, 8'h02, 1'b0, 1'b1, {8'h03, 1'b0});
        wait_done8("timeout_b2b_first");
        a8 = 8'h7F;
        b8 = 8'h01;
        cin8 = 1'b0;
        start8 = 1'b1;
        q8.push_back({8'h80, 1'b0});
        @(posedge clk);
        #1 start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check(sum8 === 8'h03 && busy8 === 1'b1, "b2b_hold", {23'd0, busy8, sum8}, 32'h103);
        end
        @(negedge clk);
        check(done8 === 1'b1, "b2b_done_timing", {31'd0, done8}, 32'd1);

        // Reset in the middle of an add aborts it.
        start8_op(8'hFF, 8'hFF, 1'b0, 1'b0, 9'd0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check({busy8, done8, sum8, cout8} === 11'd0, "midop_reset", {21'd0, busy8, done8, sum8, cout8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check(sum8 === 8'h00 && busy8 === 1'b0, "midop_no_result", {23'd0, busy8, sum8}, 32'd0);
        start8_op(8'h12, 8'h34, 1'b1, 1'b1, {8'h47, 1'b0});
        wait_done8("timeout_after_reset");

        // WIDTH=4 instance: 0xF + 0x1 = 0x0 carry 1 after 4 cycles.
        @(negedge clk);
        a4 = 4'hF;
        b4 = 4'h1;
        cin4 = 1'b0;
        start4 = 1'b1;
        q4.push_back({4'h0, 1'b1});
        @(posedge clk);
        #1 start4 = 1'b0;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (busy4 === 1'b1 && n < 60) begin
                n++;
                @(negedge clk);
            end
            check(n == 4, "w4_busy_cycles", 32'(n), 32'd4);
            check(done4 === 1'b1, "w4_done_after_busy", {31'd0, done4}, 32'd1);
        end

        repeat (5) @(negedge clk);
        check(q8.size() == 0, "q8_drained", 32'(q8.size()), 32'd0);
        check(q4.size() == 0, "q4_drained", 32'(q4.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder that processes operands LSB-first, one bit per clock, through a single full-adder cell built from two half-adder instances plus an OR gate for the carry. It sits downstream of the operand source and upstream of the half-adder cells. It loads both operands into shift registers, drives the adder cell each cycle with the current bit pair and a registered carry, and collects the sum bits. It trades latency for area in datapaths where a ripple-carry adder is too large.

## Interface
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.
- clk  input  1  rising-edge clock; the block has one clock domain.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when a result is committed.
- sum  output  WIDTH  registered result of the last completed addition.
- cout  output  1  registered carry-out of the last completed addition.

## Operation
- State machine, two states:
  - IDLE (busy=0).
  - SHIFT (busy=1).
- IDLE, start=1 at a rising edge:
  - a_sr<=a, b_sr<=b, carry<=cin, sum_sr<=0, bit count<=0.
  - Next state is SHIFT.
- IDLE, start=0: all registers hold.
- SHIFT, each edge:
  - Adder-cell inputs are a_sr[0], b_sr[0] and carry.
    - s_bit = a_sr[0]^b_sr[0]^carry.
    - c_next = (a_sr[0]&b_sr[0]) | ((a_sr[0]^b_sr[0])&carry), built from the two half-adder instances plus OR.
  - a_sr and b_sr shift right by one.
  - sum_sr shifts right with s_bit inserted at the MSB.
  - carry<=c_next; count increments.
- SHIFT, edge processing bit WIDTH-1:
  - sum<={s_bit, sum_sr[WIDTH-1:1]}, cout<=c_next, done<=1.
  - Next state is IDLE.
- done is 1 only in the cycle after the committing edge and is cleared on the next edge.
- sum and cout change only at a commit. They hold their value while the next addition runs.
- start while busy=1 is ignored. No queuing; the operands on a, b and cin are not captured.
- Arithmetic is modulo 2^WIDTH; overflow appears only on cout. There is no signed interpretation.
- Count register width is clog2(WIDTH)+1 bits. Terminal value is WIDTH-1.

## Timing
- Reset values, async, taking effect immediately:
  - Outputs: busy=0, done=0, sum=0, cout=0.
  - Internal: state=IDLE, with all internal registers at 0.
- Reset during SHIFT aborts the operation. done does not pulse, and sum/cout go to 0.
- Latency: start is accepted at edge E. busy=1 from E to edge E+WIDTH. done=1 and the result is valid in the cycle after edge E+WIDTH.
- Throughput: a start in the done cycle is accepted, since the state is already IDLE. This gives back-to-back additions every WIDTH cycles.
- Simultaneous done and start: the new operands load and sum keeps the just-committed value.
- busy is registered and is a pure function of the state. done is registered.

## Test plan
- Reset then idle: assert rst mid-cycle -> outputs go to 0 without waiting for a clock edge. Then hold start=0 for 20 cycles -> busy, done, sum and cout stay 0.
- Basic add, WIDTH=8: a=0x5A, b=0x3C, cin=0 -> done 8 edges after accept, sum=0x96, cout=0. busy is high for exactly 8 cycles.
- Carry chain, WIDTH=8:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Busy protection: start 0x10+0x20, then pulse start with a=0xAA, b=0x55 at cycle 3 -> result is 0x30 and no second done follows.
- Back-to-back: start 0x01+0x02, then start 0x7F+0x01 in the done cycle -> sum=0x03 holds for 8 cycles, then becomes 0x80 with cout=0.
- Reset mid-op and a second parameter: rst at cycle 4 of 0xFF+0xFF -> no done, sum=0; the next add runs normally. A WIDTH=4 instance: 0xF+0x1, cin=0 -> sum=0x0, cout=1 after 4 cycles.
